fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end replacing the free-running PC/+4/branch-mux path.

---
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. Owns the fetch PC, issues requests to
// instruction memory over a valid/ready handshake, and tracks outstanding
// requests in a PC queue so each in-order response can be paired with its
// address. Fetched {instr, pc} pairs are buffered in a FIFO and offered to
// decode. A redirect flushes the FIFO and marks all outstanding requests as
// stale; their responses are discarded as they return.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                XLEN         = 64,
   parameter int                ILEN         = 32,
   parameter int                FIFO_DEPTH   = 4,
   parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              reset,          // asynchronous, active-low
   // instruction memory request
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   // instruction memory response (in request order)
   input  logic              imem_rsp_valid,
   input  logic [ILEN-1:0]   imem_rsp_data,
   // redirect from execute
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   // decode port
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ILEN-1:0]   id_instr,
   output logic [XLEN-1:0]   id_pc,
   // sticky error: response with nothing outstanding
   output logic              rsp_err
);

   localparam int              AW          = $clog2(FIFO_DEPTH);
   localparam int              CW          = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]     DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP     = XLEN'(ILEN / 8);

   // architectural state
   logic [XLEN-1:0] r_fetch_pc;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   r_in_flight;
   logic [CW-1:0]   r_drop_cnt;
   logic            r_rsp_err;

   // fetch buffer
   logic [ILEN-1:0] r_fifo_instr [FIFO_DEPTH];
   logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;

   // addresses of issued requests, oldest first
   logic [XLEN-1:0] r_pcq_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_pcq_wr;
   logic [AW-1:0]   r_pcq_rd;

   // control
   logic [CW:0]     w_credit_sum;
   logic            w_req_valid;
   logic            w_fire;
   logic            w_rsp_take;
   logic            w_rsp_stray;
   logic            w_rsp_drop;
   logic            w_push;
   logic            w_pop;
   logic            w_not_empty;
   logic [CW-1:0]   w_count_nxt;
   logic [CW-1:0]   w_in_flight_nxt;
   logic [CW-1:0]   w_drop_nxt;

   // Credit: buffered plus outstanding words may never exceed the buffer size,
   // so every response that is not stale is guaranteed a slot. Requests are
   // held off during reset and in a redirect cycle.
   assign w_credit_sum = {1'b0, r_count} + {1'b0, r_in_flight};
   assign w_req_valid  = reset && !redirect_valid && (w_credit_sum < DEPTH_LIMIT);
   assign w_fire       = w_req_valid && imem_req_ready;

   // Response classification. A response with nothing outstanding is ignored.
   assign w_rsp_take   = imem_rsp_valid && (r_in_flight != '0);
   assign w_rsp_stray  = imem_rsp_valid && (r_in_flight == '0);
   assign w_rsp_drop   = w_rsp_take && (r_drop_cnt != '0);
   assign w_push       = w_rsp_take && !w_rsp_drop && !redirect_valid;

   // Decode handshake; a pop in a redirect cycle is void.
   assign w_not_empty  = (r_count != '0);
   assign w_pop        = w_not_empty && id_ready && !redirect_valid;

   // Next values of the three occupancy counters.
   always_comb begin
      // NOTE: every variable gets a default before any condition, otherwise
      // a path that skips the assignment infers a latch.
      w_in_flight_nxt = r_in_flight;
      w_count_nxt     = r_count;
      w_drop_nxt      = r_drop_cnt;

      if (w_fire)     w_in_flight_nxt = w_in_flight_nxt + CW'(1);
      if (w_rsp_take) w_in_flight_nxt = w_in_flight_nxt - CW'(1);

      if (redirect_valid) begin
         // Everything still outstanding after this cycle's response is stale.
         w_count_nxt = '0;
         w_drop_nxt  = w_in_flight_nxt;
      end else begin
         if (w_push)     w_count_nxt = w_count_nxt + CW'(1);
         if (w_pop)      w_count_nxt = w_count_nxt - CW'(1);
         if (w_rsp_drop) w_drop_nxt  = w_drop_nxt - CW'(1);
      end
   end

   // Control state: PC, counters, queue pointers and the sticky error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         r_fetch_pc  <= RESET_VECTOR;
         r_count     <= '0;
         r_in_flight <= '0;
         r_drop_cnt  <= '0;
         r_rsp_err   <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_pcq_wr    <= '0;
         r_pcq_rd    <= '0;
      end else begin
         r_count     <= w_count_nxt;
         r_in_flight <= w_in_flight_nxt;
         r_drop_cnt  <= w_drop_nxt;

         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
         end else if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;   // wraps modulo 2^XLEN
         end

         if (w_rsp_stray) begin
            r_rsp_err <= 1'b1;
         end

         // The PC queue mirrors outstanding requests and is never flushed:
         // stale entries retire one by one as their responses arrive.
         if (w_fire)     r_pcq_wr <= r_pcq_wr + AW'(1);
         if (w_rsp_take) r_pcq_rd <= r_pcq_rd + AW'(1);

         if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         end
      end
   end

   // Storage arrays: write-only on request issue and response push.
   always_ff @(posedge clk) begin
      // NOTE: the arrays carry no reset; validity is tracked by the counters,
      // and the decode outputs are masked to zero whenever the buffer is empty.
      if (w_fire) begin
         r_pcq_mem[r_pcq_wr] <= r_fetch_pc;
      end
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
         r_fifo_pc[r_wr_ptr]    <= r_pcq_mem[r_pcq_rd];
      end
   end

   // Outputs
   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign id_valid       = w_not_empty;
   assign id_instr       = w_not_empty ? r_fifo_instr[r_rd_ptr] : '0;
   assign id_pc          = w_not_empty ? r_fifo_pc[r_rd_ptr]    : '0;
   assign rsp_err        = r_rsp_err;

   // Structural invariants of the credit scheme.
   a_drop_le_in_flight : assert property (@(posedge clk) disable iff (!reset)
      r_drop_cnt <= r_in_flight);
   a_credit_bound : assert property (@(posedge clk) disable iff (!reset)
      w_credit_sum <= DEPTH_LIMIT);
   a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
      !(w_push && !w_pop && (w_count_nxt == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Two instances share all inputs: dut_a uses
// the default configuration, dut_b uses an 8-entry buffer and a reset vector
// just below the top of the address space. A select bit chooses whose
// outputs drive the bench's memory model and checks. The memory model
// answers accepted requests in order, one cycle later when enabled, or on
// demand through a response budget.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [63:0] RV_B = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk;
   logic        reset;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_ready;

   logic        a_req_valid, b_req_valid;
   logic [63:0] a_req_addr,  b_req_addr;
   logic        a_id_valid,  b_id_valid;
   logic [31:0] a_id_instr,  b_id_instr;
   logic [63:0] a_id_pc,     b_id_pc;
   logic        a_rsp_err,   b_rsp_err;

   logic        sel;
   logic        m_req_valid;
   logic [63:0] m_req_addr;
   logic        m_id_valid;
   logic [31:0] m_id_instr;
   logic [63:0] m_id_pc;
   logic        m_rsp_err;

   assign m_req_valid = sel ? b_req_valid : a_req_valid;
   assign m_req_addr  = sel ? b_req_addr  : a_req_addr;
   assign m_id_valid  = sel ? b_id_valid  : a_id_valid;
   assign m_id_instr  = sel ? b_id_instr  : a_id_instr;
   assign m_id_pc     = sel ? b_id_pc     : a_id_pc;
   assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

   fetch_unit dut_a (
      .clk(clk), .reset(reset),
      .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(a_id_valid), .id_ready(id_ready), .id_instr(a_id_instr), .id_pc(a_id_pc),
      .rsp_err(a_rsp_err)
   );

   fetch_unit #(.FIFO_DEPTH(8), .RESET_VECTOR(RV_B)) dut_b (
      .clk(clk), .reset(reset),
      .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(b_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(b_id_valid), .id_ready(id_ready), .id_instr(b_id_instr), .id_pc(b_id_pc),
      .rsp_err(b_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc;
   bit          mem_auto;
   int          rsp_budget;
   logic [63:0] pend_q[$];
   logic [63:0] fire_q[$];
   logic [63:0] pop_pc_q[$];
   logic [31:0] pop_instr_q[$];

   // values seen during the most recent tick's cycle
   logic        s_req_valid;
   logic [63:0] s_req_addr;
   logic        s_id_valid;
   logic [63:0] s_id_pc;
   logic [31:0] s_id_instr;

   // instruction word the memory model returns for an address
   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle, entered and left at a falling edge.
   task automatic tick();
      cyc++;
      #1;
      s_req_valid = m_req_valid;
      s_req_addr  = m_req_addr;
      s_id_valid  = m_id_valid;
      s_id_pc     = m_id_pc;
      s_id_instr  = m_id_instr;
      if (m_req_valid && imem_req_ready) fire_q.push_back(m_req_addr);
      if (m_req_valid && imem_req_ready) pend_q.push_back(m_req_addr);
      if (m_id_valid && id_ready && !redirect_valid) begin
         pop_pc_q.push_back(m_id_pc);
         pop_instr_q.push_back(m_id_instr);
      end
      @(posedge clk);
      @(negedge clk);
      if (pend_q.size() > 0 && (mem_auto || rsp_budget > 0)) begin
         logic [63:0] a;
         a = pend_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(a);
         if (rsp_budget > 0) rsp_budget--;
      end else begin
         imem_rsp_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input bit which);
      @(negedge clk);
      reset          = 1'b0;
      sel            = which;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      mem_auto       = 1'b0;
      rsp_budget     = 0;
      pend_q.delete();
      fire_q.delete();
      pop_pc_q.delete();
      pop_instr_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      sel            = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", m_req_valid); end
      n_checks++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", m_id_valid); end
      n_checks++; if (m_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", m_rsp_err); end
      n_checks++; if (m_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", m_id_instr); end
      n_checks++; if (m_id_pc !== 64'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", m_id_pc); end
      n_checks++; if (m_req_addr !== 64'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h want 0", m_req_addr); end
   endtask

   task automatic test_stream();
      int first_valid;
      do_reset(1'b0);
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      mem_auto       = 1'b1;
      first_valid    = 0;
      repeat (10) begin
         tick();
         if (s_id_valid && first_valid == 0) first_valid = cyc;
      end
      n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL stream_first_valid_cycle: got %0d want 3", first_valid); end
      n_checks++; if (pop_pc_q.size() < 4) begin n_fail++; $display("FAIL stream_pop_count: got %0d want >=4", pop_pc_q.size()); end
      for (int i = 0; i < 4; i++) begin
         logic [63:0] exp_pc;
         exp_pc = 64'(4 * i);
         n_checks++; if (fire_q[i] !== exp_pc) begin n_fail++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, fire_q[i], exp_pc); end
         n_checks++; if (pop_pc_q[i] !== exp_pc) begin n_fail++; $display("FAIL stream_id_pc[%0d]: got %h want %h", i, pop_pc_q[i], exp_pc); end
         n_checks++; if (pop_instr_q[i] !== instr_of(exp_pc)) begin n_fail++; $display("FAIL stream_id_instr[%0d]: got %h want %h", i, pop_instr_q[i], instr_of(exp_pc)); end
      end
      n_checks++; if (m_rsp_err !== 1'b0) begin n_fail++; $display("FAIL stream_rsp_err: got %b want 0", m_rsp_err); end
   endtask

   task automatic test_backpressure();
      bit stable;
      do_reset(1'b0);
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      mem_auto       = 1'b1;
      stable         = 1'b1;
      repeat (12) begin
         tick();
         if (s_id_valid && (s_id_pc !== 64'h0 || s_id_instr !== instr_of(64'h0))) stable = 1'b0;
      end
      n_checks++; if (fire_q.size() !== 4) begin n_fail++; $display("FAIL bp_request_count: got %0d want 4", fire_q.size()); end
      n_checks++; if (fire_q[3] !== 64'hC) begin n_fail++; $display("FAIL bp_last_addr: got %h want c", fire_q[3]); end
      n_checks++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", s_req_valid); end
      n_checks++; if (s_id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_id_valid: got %b want 1", s_id_valid); end
      n_checks++; if (s_id_pc !== 64'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 0", s_id_pc); end
      n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_head_stable: got %b want 1", stable); end
      n_checks++; if (m_rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_rsp_err: got %b want 0", m_rsp_err); end
   endtask

   task automatic test_redirect_flush();
      do_reset(1'b1);
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      repeat (5) tick();
      imem_req_ready = 1'b0;
      n_checks++; if (fire_q.size() !== 5) begin n_fail++; $display("FAIL flush_setup_requests: got %0d want 5", fire_q.size()); end
      rsp_budget = 2;
      repeat (3) tick();
      n_checks++; if (m_id_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup_valid: got %b want 1", m_id_valid); end
      n_checks++; if (m_id_pc !== RV_B) begin n_fail++; $display("FAIL flush_setup_head: got %h want %h", m_id_pc, RV_B); end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      imem_req_ready = 1'b1;
      mem_auto       = 1'b1;
      tick();
      n_checks++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_in_redirect: got %b want 0", s_req_valid); end
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      n_checks++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_id_valid_next: got %b want 0", m_id_valid); end
      tick();
      n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 64'h100) begin n_fail++; $display("FAIL flush_first_req: got v=%b a=%h want v=1 a=100", s_req_valid, s_req_addr); end
      repeat (10) tick();
      n_checks++; if (pop_pc_q.size() < 2) begin n_fail++; $display("FAIL flush_pop_count: got %0d want >=2", pop_pc_q.size()); end
      n_checks++; if (pop_pc_q[0] !== 64'h100) begin n_fail++; $display("FAIL flush_first_pc: got %h want 100", pop_pc_q[0]); end
      n_checks++; if (pop_instr_q[0] !== instr_of(64'h100)) begin n_fail++; $display("FAIL flush_first_instr: got %h want %h", pop_instr_q[0], instr_of(64'h100)); end
      n_checks++; if (pop_pc_q[1] !== 64'h104) begin n_fail++; $display("FAIL flush_second_pc: got %h want 104", pop_pc_q[1]); end
   endtask

   task automatic test_redirect_collision();
      do_reset(1'b0);
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      repeat (2) tick();
      imem_req_ready = 1'b0;
      rsp_budget     = 1;
      repeat (2) tick();
      n_checks++; if (m_id_valid !== 1'b1 || m_id_pc !== 64'h0) begin n_fail++; $display("FAIL coll_setup: got v=%b pc=%h want v=1 pc=0", m_id_valid, m_id_pc); end
      rsp_budget = 1;
      tick();                       // response for pc 4 now presented
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      tick();                       // redirect, response and pop together
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      mem_auto       = 1'b1;
      n_checks++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL coll_id_valid_next: got %b want 0", m_id_valid); end
      n_checks++; if (pop_pc_q.size() !== 0) begin n_fail++; $display("FAIL coll_pop_void: got %0d pops want 0", pop_pc_q.size()); end
      repeat (6) tick();
      n_checks++; if (pop_pc_q[0] !== 64'h200) begin n_fail++; $display("FAIL coll_first_pc: got %h want 200", pop_pc_q[0]); end
      n_checks++; if (pop_pc_q[1] !== 64'h204) begin n_fail++; $display("FAIL coll_second_pc: got %h want 204", pop_pc_q[1]); end
      n_checks++; if (pop_instr_q[0] !== instr_of(64'h200)) begin n_fail++; $display("FAIL coll_first_instr: got %h want %h", pop_instr_q[0], instr_of(64'h200)); end
   endtask

   task automatic test_pc_wrap();
      do_reset(1'b1);
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      mem_auto       = 1'b1;
      repeat (4) tick();
      n_checks++; if (fire_q[0] !== RV_B) begin n_fail++; $display("FAIL wrap_first_addr: got %h want %h", fire_q[0], RV_B); end
      n_checks++; if (fire_q[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_second_addr: got %h want 0", fire_q[1]); end
      n_checks++; if (pop_pc_q[1] !== 64'h0) begin n_fail++; $display("FAIL wrap_second_pc: got %h want 0", pop_pc_q[1]); end
   endtask

   task automatic test_reset_midflight();
      do_reset(1'b0);
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      repeat (3) tick();
      imem_req_ready = 1'b0;
      rsp_budget     = 1;
      repeat (2) tick();
      n_checks++; if (m_id_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_setup_valid: got %b want 1", m_id_valid); end
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b want 0", m_req_valid); end
      n_checks++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_id_valid: got %b want 0", m_id_valid); end
      n_checks++; if (m_id_instr !== 32'h0 || m_id_pc !== 64'h0) begin n_fail++; $display("FAIL midrst_id_data: got %h/%h want 0/0", m_id_instr, m_id_pc); end
      pend_q.delete();
      rsp_budget = 0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      n_checks++; if (m_rsp_err !== 1'b1) begin n_fail++; $display("FAIL stray_rsp_err: got %b want 1", m_rsp_err); end
      n_checks++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL stray_fifo_empty: got %b want 0", m_id_valid); end
      repeat (3) tick();
      n_checks++; if (m_rsp_err !== 1'b1) begin n_fail++; $display("FAIL stray_rsp_err_sticky: got %b want 1", m_rsp_err); end
      n_checks++; if (m_id_valid !== 1'b0) begin n_fail++; $display("FAIL stray_fifo_still_empty: got %b want 0", m_id_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_redirect_collision();
      test_pc_wrap();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
